// File: rtl/bw_io_ddr_vref_pkg.sv
`default_nettype none
// ============================================================================
// bw_io_ddr_vref_pkg : shared types and defaults for the DDR vref sequencer
// Revision : 1.0
// ============================================================================
package bw_io_ddr_vref_pkg;

  localparam int         CODE_W_DEF   = 8;
  localparam logic [7:0] RST_CODE_DEF = 8'h80;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_t;

endpackage
`default_nettype wire

// File: rtl/bw_io_ddr_vref_tick.sv
`default_nettype none
// ============================================================================
// bw_io_ddr_vref_tick : hold-gated modulo-COUNT counter with terminal pulse
// Revision : 1.0
// ============================================================================
module bw_io_ddr_vref_tick #(
  parameter int COUNT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_hold,
  input  logic i_clr,
  output logic o_tc
);

  localparam int               CNT_W  = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(COUNT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Terminal pulse is not masked by i_clr: a step due this cycle still happens.
  assign o_tc = i_en & ~i_hold & (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (reset || i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= o_tc ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bw_io_ddr_vref_seq.sv
`default_nettype none
// ============================================================================
// bw_io_ddr_vref_seq : ramps the pad vref code one LSB per step to a target,
// then settles. Optional direct load: BW_IO_DDR_VREF_SEQ_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module bw_io_ddr_vref_seq
  import bw_io_ddr_vref_pkg::*;
#(
  parameter int                CODE_W     = CODE_W_DEF,
  parameter int                STEP_DIV   = 16,
  parameter int                SETTLE_CYC = 64,
  parameter logic [CODE_W-1:0] RST_CODE   = CODE_W'(RST_CODE_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tgt_vld,
  input  logic [CODE_W-1:0] tgt_code,
  input  logic              hold,
`ifdef BW_IO_DDR_VREF_SEQ_BYPASS_EN
  input  logic              byp,
`endif
  output logic              tgt_ack,
  output logic [CODE_W-1:0] vref_code,
  output logic              code_upd,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] r_tgt;
  logic              r_ack;
  logic              r_upd;
  logic              r_done;

  logic              w_step_tc;
  logic              w_settle_tc;
  logic              w_byp;
  dir_t              w_dir;
  logic [CODE_W-1:0] w_code_step;
  logic [CODE_W-1:0] w_code_nxt;

`ifdef BW_IO_DDR_VREF_SEQ_BYPASS_EN
  assign w_byp = tgt_vld & byp;
`else
  assign w_byp = 1'b0;
`endif

  bw_io_ddr_vref_tick #(.COUNT(STEP_DIV)) u_step_div (
    .clk    (clk),
    .reset  (reset),
    .i_en   (r_state == RAMP),
    .i_hold (hold),
    .i_clr  (tgt_vld),
    .o_tc   (w_step_tc)
  );

  bw_io_ddr_vref_tick #(.COUNT(SETTLE_CYC)) u_settle (
    .clk    (clk),
    .reset  (reset),
    .i_en   (r_state == SETTLE),
    .i_hold (hold),
    .i_clr  (tgt_vld),
    .o_tc   (w_settle_tc)
  );

  // In RAMP the target never equals the code, so the step never wraps.
  always_comb begin
    w_dir       = (r_tgt > r_code) ? UP : DN;
    w_code_step = (w_dir == UP) ? r_code + CODE_W'(1) : r_code - CODE_W'(1);
    w_code_nxt  = w_step_tc ? w_code_step : r_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_code  <= RST_CODE;
      r_tgt   <= RST_CODE;
      r_ack   <= 1'b0;
      r_upd   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ack  <= tgt_vld;
      r_upd  <= 1'b0;
      r_done <= 1'b0;
      if (w_byp) begin
        r_tgt   <= tgt_code;
        r_code  <= tgt_code;
        r_upd   <= (tgt_code != r_code);
        r_state <= SETTLE;
      end else begin
        if (w_step_tc) begin
          r_code <= w_code_step;
          r_upd  <= 1'b1;
        end
        // A new target is judged against the code after any coincident step.
        if (tgt_vld) begin
          r_tgt   <= tgt_code;
          r_state <= (tgt_code == w_code_nxt) ? SETTLE : RAMP;
        end else begin
          case (r_state)
            RAMP: begin
              if (w_step_tc && (w_code_step == r_tgt)) r_state <= SETTLE;
            end
            SETTLE: begin
              if (w_settle_tc) begin
                r_done  <= 1'b1;
                r_state <= IDLE;
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign tgt_ack   = r_ack;
  assign vref_code = r_code;
  assign code_upd  = r_upd;
  assign done      = r_done;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bw_io_ddr_vref_seq.sv
`default_nettype none
// ============================================================================
// tb_bw_io_ddr_vref_seq : directed self-checking bench for bw_io_ddr_vref_seq
// Revision : 1.0
// ============================================================================
module tb_bw_io_ddr_vref_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tgt_vld = 1'b0;
  logic [7:0] tgt_code = 8'h00;
  logic       hold = 1'b0;
`ifdef BW_IO_DDR_VREF_SEQ_BYPASS_EN
  logic       byp = 1'b0;
`endif
  logic       tgt_ack;
  logic [7:0] vref_code;
  logic       code_upd;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int t = 0;

  always #5 clk = ~clk;

  bw_io_ddr_vref_seq dut (
    .clk       (clk),
    .reset     (reset),
    .tgt_vld   (tgt_vld),
    .tgt_code  (tgt_code),
    .hold      (hold),
`ifdef BW_IO_DDR_VREF_SEQ_BYPASS_EN
    .byp       (byp),
`endif
    .tgt_ack   (tgt_ack),
    .vref_code (vref_code),
    .code_upd  (code_upd),
    .busy      (busy),
    .done      (done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles until code_upd is seen (bounded); also counts done pulses on the way.
  task automatic wait_upd(input int lim, output int n, output int dn);
    n = 0; dn = 0;
    do begin
      cyc(); n++;
      if (done) dn++;
    end while (!code_upd && n < lim);
  endtask

  task automatic wait_done(input int lim, output int n, output int up);
    n = 0; up = 0;
    do begin
      cyc(); n++;
      if (code_upd) up++;
    end while (!done && n < lim);
  endtask

  initial begin
    int n, x, t0, chg;
    logic [7:0] exp_code;

    // ---- reset state
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_vref", vref_code, 8'h80);
    chk("rst_busy", busy, 0);
    chk("rst_ack",  tgt_ack, 0);
    chk("rst_upd",  code_upd, 0);
    chk("rst_done", done, 0);

    // ---- ramp up 80 -> 84
    tgt_vld = 1'b1; tgt_code = 8'h84;
    cyc();
    tgt_vld = 1'b0;
    chk("up_ack",  tgt_ack, 1);
    chk("up_busy", busy, 1);
    chk("up_vref0", vref_code, 8'h80);
    for (int i = 1; i <= 4; i++) begin
      wait_upd(100, n, x);
      exp_code = 8'h80 + 8'(i);
      chk("up_step_cyc", n, 16);
      chk("up_step_val", vref_code, exp_code);
    end
    wait_done(200, n, x);
    chk("up_settle_cyc", n, 64);
    chk("up_settle_upd", x, 0);
    chk("up_busy_end", busy, 0);
    cyc();
    chk("up_done_pulse", done, 0);

    // ---- ramp down 84 -> 80 with 40 cycles of hold
    tgt_vld = 1'b1; tgt_code = 8'h80;
    cyc();
    tgt_vld = 1'b0;
    t0 = t;
    repeat (20) cyc();
    chk("dn_first_step", vref_code, 8'h83);
    hold = 1'b1;
    chg = 0;
    repeat (40) begin
      cyc();
      if (code_upd || vref_code != 8'h83) chg++;
    end
    hold = 1'b0;
    chk("dn_hold_frozen", chg, 0);
    n = 0;
    do begin cyc(); n++; end while (!(code_upd && vref_code == 8'h80) && n < 200);
    chk("dn_total_cyc", t - t0, 104);
    chk("dn_final", vref_code, 8'h80);
    wait_done(200, n, x);
    chk("dn_settle_cyc", n, 64);

    // ---- reversal: target 90 then 7E on ramp cycle 20
    tgt_vld = 1'b1; tgt_code = 8'h90;
    cyc();
    tgt_vld = 1'b0;
    repeat (19) cyc();
    chk("rev_pre", vref_code, 8'h81);
    tgt_vld = 1'b1; tgt_code = 8'h7E;
    cyc();
    tgt_vld = 1'b0;
    chk("rev_ack", tgt_ack, 1);
    chk("rev_nojump", vref_code, 8'h81);
    for (int i = 0; i < 3; i++) begin
      wait_upd(100, n, x);
      exp_code = 8'h80 - 8'(i);
      chk("rev_step_cyc", n, 16);
      chk("rev_step_val", vref_code, exp_code);
      chk("rev_no_done", x, 0);
    end
    wait_done(200, n, x);
    chk("rev_settle_cyc", n, 64);
    chk("rev_final", vref_code, 8'h7E);

    // ---- target equal to current code: settle only
    reset = 1'b1; cyc(); reset = 1'b0;
    tgt_vld = 1'b1; tgt_code = 8'h80;
    cyc();
    tgt_vld = 1'b0;
    chk("eq_ack",  tgt_ack, 1);
    chk("eq_busy", busy, 1);
    wait_done(200, n, x);
    chk("eq_settle_cyc", n, 64);
    chk("eq_no_upd", x, 0);
    chk("eq_vref", vref_code, 8'h80);

    // ---- reset mid-ramp at 83
    tgt_vld = 1'b1; tgt_code = 8'h84;
    cyc();
    tgt_vld = 1'b0;
    repeat (3) wait_upd(100, n, x);
    chk("mr_at83", vref_code, 8'h83);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mr_vref", vref_code, 8'h80);
    chk("mr_busy", busy, 0);
    chk("mr_upd",  code_upd, 0);
    chg = 0;
    repeat (100) begin
      cyc();
      if (done || code_upd || busy) chg++;
    end
    chk("mr_quiet", chg, 0);

`ifdef BW_IO_DDR_VREF_SEQ_BYPASS_EN
    // ---- bypass load under hold
    hold = 1'b1; byp = 1'b1; tgt_vld = 1'b1; tgt_code = 8'hC0;
    cyc();
    tgt_vld = 1'b0; byp = 1'b0;
    chk("byp_vref", vref_code, 8'hC0);
    chk("byp_upd",  code_upd, 1);
    chk("byp_busy", busy, 1);
    chg = 0;
    repeat (30) begin
      cyc();
      if (done || vref_code != 8'hC0) chg++;
    end
    chk("byp_hold", chg, 0);
    hold = 1'b0;
    wait_done(200, n, x);
    chk("byp_settle_cyc", n, 64);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
